// File: rtl/dout_event_receiver_if.sv
// -----------------------------------------------------------------------------
// dout_event_receiver_if
//
// Bundles the signals of the SURF readout byte link with the payload stream
// that comes out of the receiver. Everything runs in the ifclk domain.
//
// Signals:
//   dout_data_i        8  received byte (transmitter -> receiver)
//   dout_data_valid_i  1  byte qualifier (transmitter -> receiver)
//   dout_data_phase_o  1  one-cycle pacing strobe (receiver -> transmitter)
//   m_axis_tdata       8  payload byte (receiver -> sink)
//   m_axis_tvalid      1  payload qualifier; the link has no backpressure
//   m_axis_tlast       1  last payload byte of an event
//
// Modports:
//   slave  : the receiver side (consumes bytes, drives phase and payload)
//   master : the transmitter/sink side (drives bytes, observes the rest)
// -----------------------------------------------------------------------------
interface dout_event_receiver_if;
  logic [7:0] dout_data_i;
  logic       dout_data_valid_i;
  logic       dout_data_phase_o;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tlast;

  modport slave (
    input  dout_data_i,
    input  dout_data_valid_i,
    output dout_data_phase_o,
    output m_axis_tdata,
    output m_axis_tvalid,
    output m_axis_tlast
  );

  modport master (
    output dout_data_i,
    output dout_data_valid_i,
    input  dout_data_phase_o,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  m_axis_tlast
  );
endinterface

// File: rtl/dout_event_receiver.sv
// -----------------------------------------------------------------------------
// dout_event_receiver
//
// Far end of the SURF readout byte link. Deframes the ifclk-domain byte stream
// into events: a 4-byte header (event number, trigger time) followed by
// PAYLOAD_BYTES payload bytes that are forwarded as a byte stream with tlast.
// Also drives the free-running phase strobe that paces the transmitter, and
// aborts an event when the link goes idle for TIMEOUT cycles mid-event.
//
// Optional feature (macro DOUT_RX_SEQCHK_EN): checks each received event
// number against the expected one and pulses err_seq_o on a discontinuity.
// Without the macro err_seq_o is tied low.
//
// Ports:
//   ifclk_i         in   1   sole clock
//   ifclk_resetb_i  in   1   synchronous active-low reset
//   link            if       dout_event_receiver_if.slave (byte link + payload)
//   event_no_o      out  16  header event number, held until next header
//   trig_time_o     out  16  header trigger time, held until next header
//   hdr_valid_o     out  1   one-cycle pulse when a header completes
//   err_timeout_o   out  1   one-cycle pulse on in-event timeout abort
//   err_seq_o       out  1   one-cycle pulse on event-number mismatch
//   busy_o          out  1   high whenever an event is in progress
// -----------------------------------------------------------------------------
module dout_event_receiver #(
  parameter int PAYLOAD_BYTES = 12288,
  parameter int PHASE_PERIOD  = 4,
  parameter int TIMEOUT       = 1024
) (
  input  logic                    ifclk_i,
  input  logic                    ifclk_resetb_i,
  dout_event_receiver_if.slave    link,
  output logic [15:0]             event_no_o,
  output logic [15:0]             trig_time_o,
  output logic                    hdr_valid_o,
  output logic                    err_timeout_o,
  output logic                    err_seq_o,
  output logic                    busy_o
);

  localparam int PCW = $clog2(PAYLOAD_BYTES + 1);
  localparam int GW  = $clog2(TIMEOUT + 1);
  localparam int PHW = $clog2(PHASE_PERIOD);

  localparam logic [PCW-1:0] PAY_LAST = PCW'(PAYLOAD_BYTES - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(TIMEOUT - 1);
  localparam logic [PHW-1:0] PH_LAST  = PHW'(PHASE_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } state_t;

  // Registered state
  state_t           state_r;
  logic [1:0]       hdr_cnt_r;
  logic [23:0]      shadow_r;      // {b0, b1, b2}; b3 is taken straight from the link
  logic [PCW-1:0]   pay_cnt_r;
  logic [GW-1:0]    gap_r;
  logic [PHW-1:0]   ph_cnt_r;
  logic             phase_r;
  logic [7:0]       tdata_r;
  logic             tvalid_r;
  logic             tlast_r;
  logic [15:0]      event_no_r;
  logic [15:0]      trig_time_r;
  logic             hdr_valid_r;
  logic             err_to_r;

  // Next-state values
  state_t           state_nxt_s;
  logic [1:0]       hdr_cnt_nxt_s;
  logic [23:0]      shadow_nxt_s;
  logic [PCW-1:0]   pay_cnt_nxt_s;
  logic [GW-1:0]    gap_nxt_s;
  logic [7:0]       tdata_nxt_s;
  logic             tvalid_nxt_s;
  logic             tlast_nxt_s;
  logic [15:0]      event_no_nxt_s;
  logic [15:0]      trig_time_nxt_s;
  logic             hdr_valid_nxt_s;
  logic             err_to_nxt_s;

  logic [7:0]       din_s;
  logic             vin_s;
  logic             hdr_done_s;
  logic [15:0]      rx_evno_s;
  logic [15:0]      rx_trig_s;

  assign din_s      = link.dout_data_i;
  assign vin_s      = link.dout_data_valid_i;
  // Header completes on the cycle the fourth byte is accepted.
  assign hdr_done_s = (state_r == ST_HDR) && vin_s && (hdr_cnt_r == 2'd3);
  assign rx_evno_s  = shadow_r[23:8];
  assign rx_trig_s  = {shadow_r[7:0], din_s};

  // Free-running phase counter and registered phase strobe (state independent).
  always_ff @(posedge ifclk_i) begin
    if (!ifclk_resetb_i) begin
      ph_cnt_r <= PHW'(0);
      phase_r  <= 1'b0;
    end else begin
      phase_r  <= (ph_cnt_r == PHW'(0));
      ph_cnt_r <= (ph_cnt_r == PH_LAST) ? PHW'(0) : ph_cnt_r + PHW'(1);
    end
  end

  // Deframer next-state and next-output logic.
  always_comb begin
    state_nxt_s     = state_r;
    hdr_cnt_nxt_s   = hdr_cnt_r;
    shadow_nxt_s    = shadow_r;
    pay_cnt_nxt_s   = pay_cnt_r;
    gap_nxt_s       = gap_r;
    tdata_nxt_s     = 8'h00;
    tvalid_nxt_s    = 1'b0;
    tlast_nxt_s     = 1'b0;
    event_no_nxt_s  = event_no_r;
    trig_time_nxt_s = trig_time_r;
    hdr_valid_nxt_s = 1'b0;
    err_to_nxt_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        // Idle cycles between events never time out.
        gap_nxt_s     = GW'(0);
        pay_cnt_nxt_s = PCW'(0);
        if (vin_s) begin
          shadow_nxt_s[23:16] = din_s;
          hdr_cnt_nxt_s       = 2'd1;
          state_nxt_s         = ST_HDR;
        end else begin
          hdr_cnt_nxt_s = 2'd0;
        end
      end

      ST_HDR: begin
        if (vin_s) begin
          gap_nxt_s = GW'(0);
          if (hdr_cnt_r == 2'd3) begin
            event_no_nxt_s  = rx_evno_s;
            trig_time_nxt_s = rx_trig_s;
            hdr_valid_nxt_s = 1'b1;
            hdr_cnt_nxt_s   = 2'd0;
            pay_cnt_nxt_s   = PCW'(0);
            state_nxt_s     = ST_PAY;
          end else begin
            case (hdr_cnt_r)
              2'd1:    shadow_nxt_s[15:8]  = din_s;
              2'd2:    shadow_nxt_s[7:0]   = din_s;
              default: shadow_nxt_s[23:16] = din_s;
            endcase
            hdr_cnt_nxt_s = hdr_cnt_r + 2'd1;
          end
        end else if (gap_r == GAP_LAST) begin
          // Abort before the header completes: published header stays as is.
          err_to_nxt_s  = 1'b1;
          gap_nxt_s     = GW'(0);
          hdr_cnt_nxt_s = 2'd0;
          state_nxt_s   = ST_IDLE;
        end else begin
          gap_nxt_s = gap_r + GW'(1);
        end
      end

      ST_PAY: begin
        if (vin_s) begin
          gap_nxt_s    = GW'(0);
          tdata_nxt_s  = din_s;
          tvalid_nxt_s = 1'b1;
          if (pay_cnt_r == PAY_LAST) begin
            tlast_nxt_s   = 1'b1;
            pay_cnt_nxt_s = PCW'(0);
            state_nxt_s   = ST_IDLE;
          end else begin
            pay_cnt_nxt_s = pay_cnt_r + PCW'(1);
          end
        end else if (gap_r == GAP_LAST) begin
          // Partial payload is dropped without a tlast.
          err_to_nxt_s  = 1'b1;
          gap_nxt_s     = GW'(0);
          pay_cnt_nxt_s = PCW'(0);
          state_nxt_s   = ST_IDLE;
        end else begin
          gap_nxt_s = gap_r + GW'(1);
        end
      end

      default: begin
        gap_nxt_s     = GW'(0);
        hdr_cnt_nxt_s = 2'd0;
        pay_cnt_nxt_s = PCW'(0);
        state_nxt_s   = ST_IDLE;
      end
    endcase
  end

  // Deframer state and output registers.
  always_ff @(posedge ifclk_i) begin
    if (!ifclk_resetb_i) begin
      state_r     <= ST_IDLE;
      hdr_cnt_r   <= 2'd0;
      shadow_r    <= 24'h000000;
      pay_cnt_r   <= PCW'(0);
      gap_r       <= GW'(0);
      tdata_r     <= 8'h00;
      tvalid_r    <= 1'b0;
      tlast_r     <= 1'b0;
      event_no_r  <= 16'h0000;
      trig_time_r <= 16'h0000;
      hdr_valid_r <= 1'b0;
      err_to_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      hdr_cnt_r   <= hdr_cnt_nxt_s;
      shadow_r    <= shadow_nxt_s;
      pay_cnt_r   <= pay_cnt_nxt_s;
      gap_r       <= gap_nxt_s;
      tdata_r     <= tdata_nxt_s;
      tvalid_r    <= tvalid_nxt_s;
      tlast_r     <= tlast_nxt_s;
      event_no_r  <= event_no_nxt_s;
      trig_time_r <= trig_time_nxt_s;
      hdr_valid_r <= hdr_valid_nxt_s;
      err_to_r    <= err_to_nxt_s;
    end
  end

`ifdef DOUT_RX_SEQCHK_EN
  logic [15:0] exp_evno_r;
  logic [15:0] exp_evno_nxt_s;
  logic        err_seq_r;
  logic        err_seq_nxt_s;

  // Sequence check: compare at header completion, then resynchronise to
  // received+1 so a single discontinuity reports exactly once.
  always_comb begin
    exp_evno_nxt_s = exp_evno_r;
    err_seq_nxt_s  = 1'b0;
    if (hdr_done_s) begin
      err_seq_nxt_s  = (rx_evno_s != exp_evno_r);
      exp_evno_nxt_s = rx_evno_s + 16'd1;
    end else begin
      exp_evno_nxt_s = exp_evno_r;
    end
  end

  // Expected event number and sequence error pulse registers.
  always_ff @(posedge ifclk_i) begin
    if (!ifclk_resetb_i) begin
      exp_evno_r <= 16'h0000;
      err_seq_r  <= 1'b0;
    end else begin
      exp_evno_r <= exp_evno_nxt_s;
      err_seq_r  <= err_seq_nxt_s;
    end
  end

  assign err_seq_o = err_seq_r;
`else
  assign err_seq_o = 1'b0;
`endif

  assign link.dout_data_phase_o = phase_r;
  assign link.m_axis_tdata      = tdata_r;
  assign link.m_axis_tvalid     = tvalid_r;
  assign link.m_axis_tlast      = tlast_r;
  assign event_no_o             = event_no_r;
  assign trig_time_o            = trig_time_r;
  assign hdr_valid_o            = hdr_valid_r;
  assign err_timeout_o          = err_to_r;
  assign busy_o                 = (state_r != ST_IDLE);

endmodule

// File: tb/tb_dout_event_receiver.sv
// -----------------------------------------------------------------------------
// tb_dout_event_receiver
//
// Directed self-checking bench for dout_event_receiver with default
// parameters (12288-byte payload, phase period 4, timeout 1024).
// Optional macro DOUT_RX_SEQCHK_EN selects the expected err_seq_o behaviour.
// -----------------------------------------------------------------------------
module tb_dout_event_receiver;

  localparam int PAY = 12288;
  localparam int TO  = 1024;
`ifdef DOUT_RX_SEQCHK_EN
  localparam int SEQ_ON = 1;
`else
  localparam int SEQ_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        resetb;
  logic [15:0] event_no;
  logic [15:0] trig_time;
  logic        hdr_valid;
  logic        err_to;
  logic        err_seq;
  logic        busy;

  always #5 clk = ~clk;

  dout_event_receiver_if link ();

  dout_event_receiver dut (
    .ifclk_i        (clk),
    .ifclk_resetb_i (resetb),
    .link           (link),
    .event_no_o     (event_no),
    .trig_time_o    (trig_time),
    .hdr_valid_o    (hdr_valid),
    .err_timeout_o  (err_to),
    .err_seq_o      (err_seq),
    .busy_o         (busy)
  );

  int checks = 0;
  int errors = 0;
  int beat, tlast_cnt, hdr_cnt, to_cnt, seq_cnt;
  int ph_model = 0;
  logic [11:0] ph_vec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    beat = 0; tlast_cnt = 0; hdr_cnt = 0; to_cnt = 0; seq_cnt = 0;
  endtask

  // One clock: sample 1 time unit after the edge and update the scoreboard.
  task automatic tick();
    logic rst_now;
    logic exp_ph;
    rst_now = resetb;
    @(posedge clk);
    #1;
    if (!rst_now) begin
      exp_ph   = 1'b0;
      ph_model = 0;
      chk("rst_outs", 32'({link.m_axis_tvalid, link.m_axis_tlast, hdr_valid,
                           err_to, err_seq, busy}), 32'h0);
      chk("rst_ids", {event_no, trig_time}, 32'h0);
    end else begin
      exp_ph   = (ph_model == 0);
      ph_model = (ph_model + 1) % 4;
    end
    chk("phase", 32'(link.dout_data_phase_o), 32'(exp_ph));
    if (link.m_axis_tvalid) begin
      chk("tdata", 32'(link.m_axis_tdata), 32'(beat[7:0]));
      beat++;
      if (link.m_axis_tlast) begin
        tlast_cnt++;
        chk("tlast_pos", beat, PAY);
      end
    end
    chk("tlast_qual", 32'(link.m_axis_tlast & ~link.m_axis_tvalid), 32'h0);
    chk("seq_with_hdr", 32'(err_seq & ~hdr_valid), 32'h0);
    hdr_cnt += int'(hdr_valid);
    to_cnt  += int'(err_to);
    seq_cnt += int'(err_seq);
  endtask

  task automatic drive(input logic v, input logic [7:0] b);
    link.dout_data_valid_i = v;
    link.dout_data_i       = b;
    tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 8'h00);
  endtask

  task automatic send_hdr(input logic [15:0] ev, input logic [15:0] tt);
    drive(1'b1, ev[15:8]);
    drive(1'b1, ev[7:0]);
    drive(1'b1, tt[15:8]);
    drive(1'b1, tt[7:0]);
  endtask

  task automatic send_payload(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 8'(i));
  endtask

  task automatic check_full_event(input string tag, input logic [15:0] ev, input logic [15:0] tt);
    chk({tag, "_hdr_cnt"}, hdr_cnt, 1);
    chk({tag, "_event_no"}, 32'(event_no), 32'(ev));
    chk({tag, "_trig"}, 32'(trig_time), 32'(tt));
    chk({tag, "_beats"}, beat, PAY);
    chk({tag, "_tlast_cnt"}, tlast_cnt, 1);
    chk({tag, "_timeouts"}, to_cnt, 0);
    chk({tag, "_busy_end"}, 32'(busy), 32'h0);
  endtask

  initial begin
    // Reset state
    resetb = 1'b0;
    link.dout_data_valid_i = 1'b0;
    link.dout_data_i       = 8'h00;
    clear_counts();
    repeat (3) tick();

    // Phase strobe after release, link idle
    resetb = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 8'h00);
      ph_vec[i] = link.dout_data_phase_o;
    end
    chk("phase_vec", 32'(ph_vec), 32'h111);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_pulses", hdr_cnt + to_cnt + seq_cnt + beat, 0);

    // Continuous full event
    clear_counts();
    send_hdr(16'h0005, 16'h1234);
    chk("a_hdr_pulse", hdr_cnt, 1);
    chk("a_busy_pay", 32'(busy), 32'h1);
    send_payload(PAY);
    check_full_event("a", 16'h0005, 16'h1234);
    drive(1'b0, 8'h00);
    chk("a_no_more_beats", beat, PAY);

    // Same event with alternate-cycle gaps and maximal 1023-cycle gaps
    clear_counts();
    drive(1'b1, 8'h00); idle(1);
    drive(1'b1, 8'h05); idle(TO - 1);
    drive(1'b1, 8'h12); idle(1);
    drive(1'b1, 8'h34);
    for (int i = 0; i < PAY; i++) begin
      if (i == 5000 || i == PAY - 1) idle(TO - 1);
      else idle(1);
      drive(1'b1, 8'(i));
    end
    check_full_event("b", 16'h0005, 16'h1234);

    // Timeout in payload
    clear_counts();
    send_hdr(16'h0009, 16'hABCD);
    send_payload(100);
    idle(TO - 1);
    chk("c_to_boundary", to_cnt, 0);
    chk("c_busy_boundary", 32'(busy), 32'h1);
    idle(1);
    chk("c_to_fire", to_cnt, 1);
    chk("c_busy_after", 32'(busy), 32'h0);
    chk("c_no_tlast", tlast_cnt, 0);
    chk("c_beats", beat, 100);
    chk("c_event_no", 32'(event_no), 32'h0009);
    // Next byte after abort is header b0
    send_hdr(16'h000A, 16'h1122);
    chk("c_hdr_after_abort", hdr_cnt, 2);
    chk("c_event_no2", 32'(event_no), 32'h000A);
    chk("c_trig2", 32'(trig_time), 32'h1122);
    idle(TO);
    chk("c_to_second", to_cnt, 2);
    // Abort inside the header leaves the published header untouched
    drive(1'b1, 8'h00);
    drive(1'b1, 8'h0B);
    idle(TO);
    chk("c_to_hdr", to_cnt, 3);
    chk("c_hdr_kept_ev", 32'(event_no), 32'h000A);
    chk("c_hdr_kept_tt", 32'(trig_time), 32'h1122);
    chk("c_hdr_no_pulse", hdr_cnt, 2);
    chk("c_busy_hdr_abort", 32'(busy), 32'h0);

    // Event sequence check (expected number restarts at 0 after reset)
    resetb = 1'b0;
    idle(2);
    resetb = 1'b1;
    clear_counts();
    send_hdr(16'h0000, 16'h0100); idle(TO);
    chk("d_seq_ev0", seq_cnt, 0);
    send_hdr(16'h0001, 16'h0101); idle(TO);
    chk("d_seq_ev1", seq_cnt, 0);
    send_hdr(16'h0003, 16'h0103);
    chk("d_seq_ev3", seq_cnt, SEQ_ON);
    idle(TO);
    send_hdr(16'h0004, 16'h0104); idle(TO);
    chk("d_seq_ev4", seq_cnt, SEQ_ON);
    send_hdr(16'hFFFF, 16'h01FF); idle(TO);
    chk("d_seq_evffff", seq_cnt, 2 * SEQ_ON);
    send_hdr(16'h0000, 16'h0200); idle(TO);
    chk("d_seq_wrap", seq_cnt, 2 * SEQ_ON);
    chk("d_hdr_cnt", hdr_cnt, 6);
    chk("d_to_cnt", to_cnt, 6);

    // Reset in the middle of a payload, then a clean event
    clear_counts();
    send_hdr(16'h0008, 16'h0000);
    send_payload(500);
    chk("e_beats_before", beat, 500);
    resetb = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b1, 8'hAA);
    resetb = 1'b1;
    idle(2);
    chk("e_busy_after_rst", 32'(busy), 32'h0);
    chk("e_tvalid_after_rst", 32'(link.m_axis_tvalid), 32'h0);
    clear_counts();
    send_hdr(16'h0007, 16'h9ABC);
    chk("e_hdr_pulse", hdr_cnt, 1);
    send_payload(PAY);
    check_full_event("e", 16'h0007, 16'h9ABC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
